frame_serializer: RTL and testbench
===================================

FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 The module SHALL have parameter R_I, default 5, meaning image rows.
REQ-002 The module SHALL have parameter C_I, default 5, meaning image columns.
REQ-003 The module SHALL have parameter W_I, default 8, meaning pixel width in bits.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have port cen, input, 1 bit: clock enable; when low, all state and outputs hold.
REQ-007 The module SHALL have port img, input, R_I*C_I*W_I bits (img_t): the parallel frame from the averaging filter.
REQ-008 The module SHALL have port img_valid, input, 1 bit: img holds a frame to transmit.
REQ-009 The module SHALL have port img_ready, output, 1 bit: the serializer can capture a frame.
REQ-010 The module SHALL have port m_data, output, W_I bits: the streamed pixel.
REQ-011 The module SHALL have port m_valid, output, 1 bit: m_data is valid.
REQ-012 The module SHALL have port m_ready, input, 1 bit: the downstream sink accepts m_data.
REQ-013 The module SHALL have port m_eol, output, 1 bit: the current pixel is the last in its row (c == C_I-1).
REQ-014 The module SHALL have port m_last, output, 1 bit: the current pixel is the last in the frame (r == R_I-1, c == C_I-1).

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-016 In IDLE, img_ready SHALL be 1 and m_valid 0; in SEND, img_ready SHALL be 0 and m_valid 1.
REQ-017 On a rising edge with cen=1 in IDLE and img_valid=1, the block SHALL register the whole img, clear row/col counters to 0, and enter SEND.
REQ-018 Pixel order SHALL be row-major: [0][0], [0][1] .. [0][C_I-1], [1][0] .. [R_I-1][C_I-1].
REQ-019 m_data SHALL equal the captured pixel at [r][c] selected by the counters; later changes on img SHALL NOT affect an in-flight frame.
REQ-020 A transfer SHALL occur on a rising edge with cen=1, m_valid=1 and m_ready=1; only then do the counters advance (c+1; on c == C_I-1, c=0 and r+1).
REQ-021 While m_valid=1 and m_ready=0, m_data, m_eol and m_last SHALL hold stable.
REQ-022 The transfer with m_last=1 SHALL return the FSM to IDLE, with img_ready=1 on the next cycle; back-to-back frames therefore cost R_I*C_I+1 cycles each.
REQ-023 Latency: with m_ready tied to 1, the first pixel SHALL appear one cycle after capture and the last pixel R_I*C_I cycles after capture.
REQ-024 With cen=0, the FSM, counters, frame register and all outputs SHALL hold regardless of img_valid or m_ready.
REQ-025 Counters SHALL be $clog2(R_I) and $clog2(C_I) bits wide (minimum 1) and SHALL never exceed R_I-1 or C_I-1.

Reset
REQ-026 When rstn=0 on a rising edge, independent of cen, the block SHALL enter IDLE with counters at 0.
REQ-027 Reset values SHALL be img_ready=1 (asserted the cycle after reset releases), m_valid=0, m_eol=0, m_last=0 and m_data=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no further pixels; the frame register need not be cleared.

Structure
REQ-029 The img_t typedef (logic unsigned [R_I-1:0][C_I-1:0][W_I-1:0]) and the default R_I/C_I/W_I constants SHALL live in the shared package img_pkg, which the averaging filter also uses.
REQ-030 The row/column counter SHALL be one sub-module, rc_counter, with ports en, clear, r, c, eol and last.

Verification
REQ-031 The bench SHALL cover reset release: rstn 0->1 with img_valid=0 -> img_ready=1, m_valid=0 and m_data=0 hold indefinitely.
REQ-032 The bench SHALL cover a streaming frame: img[r][c]=r*5+c, m_ready=1 -> 25 pixels 0..24 on consecutive cycles, m_eol on 4,9,14,19,24, m_last only on 24, img_ready=1 the next cycle.
REQ-033 The bench SHALL cover backpressure: m_ready=0 for 3 cycles at pixel [1][2] -> m_data=7 held stable, the sequence resumes at 8, and no pixel is dropped or duplicated.
REQ-034 The bench SHALL cover input isolation: img is changed to all 0xFF during SEND -> the streamed output still matches the captured frame.
REQ-035 The bench SHALL cover cen gating: cen=0 for 4 cycles mid-frame with m_ready=1 -> the outputs and the pixel index freeze, and the stream continues intact afterwards.
REQ-036 The bench SHALL cover reset mid-frame: rstn=0 at pixel [2][3] -> next cycle m_valid=0 and img_ready=1, and a new frame starts again at [0][0].

Source files
------------

// File: rtl/img_pkg.sv
// Shared image types and default geometry for the averaging filter
// and the frame serializer.
package img_pkg;

   localparam int R_I = 5;
   localparam int C_I = 5;
   localparam int W_I = 8;

   typedef logic unsigned [R_I-1:0][C_I-1:0][W_I-1:0] img_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_e;

   // Counter width for an index range of n, never narrower than 1 bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rc_counter.sv
// Row-major row/column position counter for frame streaming.
// Wraps to [0][0] after the last pixel so it never leaves range.
module rc_counter #(
   parameter int R_I = img_pkg::R_I,
   parameter int C_I = img_pkg::C_I
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              cen,
   input  logic                              en,
   input  logic                              clear,
   output logic [img_pkg::cnt_w(R_I)-1:0]    r,
   output logic [img_pkg::cnt_w(C_I)-1:0]    c,
   output logic                              eol,
   output logic                              last
);
   import img_pkg::*;

   localparam int RW = cnt_w(R_I);
   localparam int CW = cnt_w(C_I);

   logic [RW-1:0] r_q, r_d;
   logic [CW-1:0] c_q, c_d;

   assign eol  = (c_q == CW'(C_I - 1));
   assign last = eol && (r_q == RW'(R_I - 1));
   assign r    = r_q;
   assign c    = c_q;

   always_comb begin
      r_d = r_q;
      c_d = c_q;
      if (clear) begin
         r_d = '0;
         c_d = '0;
      end else if (en) begin
         if (eol) begin
            c_d = '0;
            r_d = last ? '0 : r_q + RW'(1);
         end else begin
            c_d = c_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_q <= '0;
         c_q <= '0;
      end else if (cen) begin
         r_q <= r_d;
         c_q <= c_d;
      end
   end

endmodule

// File: rtl/frame_serializer.sv
// Captures a parallel image frame and streams it pixel by pixel,
// row-major, over a valid/ready interface with row/frame markers.
module frame_serializer #(
   parameter int R_I = img_pkg::R_I,
   parameter int C_I = img_pkg::C_I,
   parameter int W_I = img_pkg::W_I
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             cen,
   input  logic [R_I-1:0][C_I-1:0][W_I-1:0] img,
   input  logic                             img_valid,
   output logic                             img_ready,
   output logic [W_I-1:0]                   m_data,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic                             m_eol,
   output logic                             m_last
);
   import img_pkg::*;

   localparam int RW = cnt_w(R_I);
   localparam int CW = cnt_w(C_I);

   ser_state_e state_q, state_d;

   logic [R_I-1:0][C_I-1:0][W_I-1:0] frame_q;

   logic          capture;
   logic          xfer;
   logic [RW-1:0] r;
   logic [CW-1:0] c;
   logic          eol;
   logic          last;

   rc_counter #(
      .R_I (R_I),
      .C_I (C_I)
   ) u_rc (
      .clk   (clk),
      .rstn  (rstn),
      .cen   (cen),
      .en    (xfer),
      .clear (capture),
      .r     (r),
      .c     (c),
      .eol   (eol),
      .last  (last)
   );

   always_comb begin
      state_d   = state_q;
      capture   = 1'b0;
      xfer      = 1'b0;
      img_ready = 1'b0;
      m_valid   = 1'b0;
      unique case (state_q)
         IDLE: begin
            img_ready = 1'b1;
            if (img_valid) begin
               capture = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            m_valid = 1'b1;
            if (m_ready) begin
               xfer = 1'b1;
               if (last) state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= IDLE;
      else if (cen) state_q <= state_d;
   end

   // Frame store needs no reset: it is only observed while in SEND.
   always_ff @(posedge clk) begin
      if (cen && capture) frame_q <= img;
   end

   assign m_data = m_valid ? frame_q[r][c] : '0;
   assign m_eol  = m_valid & eol;
   assign m_last = m_valid & last;

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: vector table, corner sequences and
// randomized traffic against a flat pixel-index reference model.
module tb_frame_serializer;
   import img_pkg::*;

   localparam int R = 5;
   localparam int C = 5;
   localparam int W = 8;
   localparam int N = R * C;

   logic         clk = 1'b0;
   logic         rstn;
   logic         cen;
   logic         img_valid;
   logic         m_ready;
   logic         img_ready;
   logic         m_valid;
   logic         m_eol;
   logic         m_last;
   logic [W-1:0] m_data;
   img_t         img;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   frame_serializer #(
      .R_I (R),
      .C_I (C),
      .W_I (W)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .cen       (cen),
      .img       (img),
      .img_valid (img_valid),
      .img_ready (img_ready),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_eol     (m_eol),
      .m_last    (m_last)
   );

   // Reference model: busy flag, flat pixel index, captured copy.
   bit           mb = 1'b0;
   int           mi = 0;
   logic [W-1:0] mf [N];

   typedef struct {
      logic         iv;
      logic         rdy;
      logic         vld;
      logic [W-1:0] d;
      logic         eol;
      logic         last;
   } vec_t;

   vec_t tbl [N+1];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] pix(input img_t im, input int k);
      return im[k / C][k % C];
   endfunction

   // One clock: drive, advance model at the edge, compare #1 later.
   task automatic cyc(input logic rs, input logic ce,
                      input logic iv, input logic mr);
      rstn = rs;
      cen = ce;
      img_valid = iv;
      m_ready = mr;
      @(posedge clk);
      if (!rs) begin
         mb = 1'b0;
         mi = 0;
      end else if (ce) begin
         if (!mb) begin
            if (iv) begin
               for (int k = 0; k < N; k++) mf[k] = pix(img, k);
               mb = 1'b1;
               mi = 0;
            end
         end else if (mr) begin
            if (mi == N - 1) mb = 1'b0;
            else mi++;
         end
      end
      #1;
      chk("img_ready", 32'(img_ready), 32'(!mb));
      chk("m_valid", 32'(m_valid), 32'(mb));
      chk("m_data", 32'(m_data), mb ? 32'(mf[mi]) : 32'd0);
      chk("m_eol", 32'(m_eol), 32'(mb && (mi % C == C - 1)));
      chk("m_last", 32'(m_last), 32'(mb && (mi == N - 1)));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (!img_ready && n < 4 * N) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b1);
         n++;
      end
      chk("drain_timeout", 32'(img_ready), 32'd1);
   endtask

   task automatic ramp_img();
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            img[r][c] = W'(r * C + c);
   endtask

   task automatic rand_img();
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            img[r][c] = W'($urandom);
   endtask

   initial begin
      logic [W-1:0] held;

      img = '0;
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);

      // Reset release with no frame offered
      for (int i = 0; i < 6; i++)
         cyc(1'b1, 1'b1, 1'b0, 1'($urandom));
      chk("rst_ready", 32'(img_ready), 32'd1);
      chk("rst_data", 32'(m_data), 32'd0);

      // Streaming frame from the vector table
      ramp_img();
      for (int k = 0; k < N; k++) begin
         tbl[k].iv   = (k == 0);
         tbl[k].rdy  = 1'b0;
         tbl[k].vld  = 1'b1;
         tbl[k].d    = W'(k);
         tbl[k].eol  = (k % 5 == 4);
         tbl[k].last = (k == 24);
      end
      tbl[N] = '{iv: 1'b0, rdy: 1'b1, vld: 1'b0,
                 d: '0, eol: 1'b0, last: 1'b0};
      for (int k = 0; k <= N; k++) begin
         cyc(1'b1, 1'b1, tbl[k].iv, 1'b1);
         chk($sformatf("tbl%0d_rdy", k), 32'(img_ready), 32'(tbl[k].rdy));
         chk($sformatf("tbl%0d_vld", k), 32'(m_valid), 32'(tbl[k].vld));
         chk($sformatf("tbl%0d_d", k), 32'(m_data), 32'(tbl[k].d));
         chk($sformatf("tbl%0d_eol", k), 32'(m_eol), 32'(tbl[k].eol));
         chk($sformatf("tbl%0d_last", k), 32'(m_last), 32'(tbl[k].last));
      end

      // Backpressure at pixel [1][2]
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
      chk("bp_at7", 32'(m_data), 32'd7);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0);
         chk("bp_hold", 32'(m_data), 32'd7);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      chk("bp_resume", 32'(m_data), 32'd8);
      drain();

      // Input isolation: img overwritten while sending
      rand_img();
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      img = '1;
      drain();

      // Clock-enable freeze mid-frame
      ramp_img();
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
      held = m_data;
      chk("cen_pre", 32'(m_data), 32'd6);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'($urandom), 1'b1);
         chk("cen_hold", 32'(m_data), 32'(held));
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      chk("cen_resume", 32'(m_data), 32'd7);
      drain();

      // Reset mid-frame at pixel [2][3]
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 13; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
      chk("mid_at13", 32'(m_data), 32'd13);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      chk("mid_vld", 32'(m_valid), 32'd0);
      chk("mid_rdy", 32'(img_ready), 32'd1);
      rand_img();
      img[0][0] = 8'hA5;
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      chk("mid_restart", 32'(m_data), 32'hA5);
      drain();

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         rand_img();
         cyc(($urandom_range(0, 99) != 0),
             ($urandom_range(0, 4) != 0),
             1'($urandom),
             ($urandom_range(0, 3) != 0));
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
